// File: rtl/arb_out_queue.sv
// Output queue behind the 4-input round-robin arbiter: stores granted beats with their
// grant tag and replays them in order, isolating consumer backpressure from the arbiter.
module arb_out_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned TAG_W = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       io_enq_valid,
  output logic                       io_enq_ready,
  input  logic [WIDTH-1:0]           io_enq_bits,
  input  logic [TAG_W-1:0]           io_enq_chosen,
  output logic                       io_deq_valid,
  input  logic                       io_deq_ready,
  output logic [WIDTH-1:0]           io_deq_bits,
  output logic [TAG_W-1:0]           io_deq_chosen,
  output logic [$clog2(DEPTH):0]     io_count
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned ENTRY_W = TAG_W + WIDTH;

  typedef struct packed {
    logic [TAG_W-1:0] chosen;
    logic [WIDTH-1:0] bits;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] enq_ptr;
  logic [PTR_W-1:0] deq_ptr;
  logic             maybe_full;

  logic             ptr_match;
  logic             empty;
  logic             full;
  logic             do_enq;
  logic             do_deq;
  logic [PTR_W-1:0] ptr_diff;
  entry_t           head;

  // Occupancy flags derive purely from state, so enq_ready never depends on deq_ready.
  always_comb begin
    ptr_match = (enq_ptr == deq_ptr);
    empty     = ptr_match & ~maybe_full;
    full      = ptr_match & maybe_full;
    do_enq    = io_enq_valid & ~full;
    do_deq    = io_deq_ready & ~empty;
    ptr_diff  = enq_ptr - deq_ptr;
    head      = mem[deq_ptr];
  end

  // Pointer, full-disambiguation flag and storage update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enq_ptr    <= '0;
      deq_ptr    <= '0;
      maybe_full <= 1'b0;
      mem        <= '{default: '0};
    end else begin
      if (do_enq) begin
        mem[enq_ptr] <= entry_t'(ENTRY_W'({io_enq_chosen, io_enq_bits}));
        enq_ptr      <= enq_ptr + PTR_W'(1);
      end
      if (do_deq) begin
        deq_ptr <= deq_ptr + PTR_W'(1);
      end
      if (do_enq != do_deq) begin
        maybe_full <= do_enq;
      end
    end
  end

  always_comb begin
    io_enq_ready  = ~full;
    io_deq_valid  = ~empty;
    io_deq_bits   = head.bits;
    io_deq_chosen = head.chosen;
    io_count      = full ? CNT_W'(DEPTH) : CNT_W'(ptr_diff);
  end

endmodule

// File: tb/tb_arb_out_queue.sv
// Directed bench for arb_out_queue: a queue-based model checked every cycle, plus
// literal expectations at the key points of each scenario.
module tb_arb_out_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned TAG_W = 2;

  logic             clk;
  logic             reset;
  logic             enq_valid;
  logic             enq_ready;
  logic [WIDTH-1:0] enq_bits;
  logic [TAG_W-1:0] enq_chosen;
  logic             deq_valid;
  logic             deq_ready;
  logic [WIDTH-1:0] deq_bits;
  logic [TAG_W-1:0] deq_chosen;
  logic [2:0]       count;

  int checks = 0;
  int errors = 0;

  logic [9:0] mq[$];

  arb_out_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .io_enq_valid (enq_valid),
    .io_enq_ready (enq_ready),
    .io_enq_bits  (enq_bits),
    .io_enq_chosen(enq_chosen),
    .io_deq_valid (deq_valid),
    .io_deq_ready (deq_ready),
    .io_deq_bits  (deq_bits),
    .io_deq_chosen(deq_chosen),
    .io_count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: a plain FIFO of {tag, payload}; reset empties it at once.
  always @(negedge reset) mq.delete();

  always @(posedge clk) begin
    if (reset) begin
      bit acc_enq;
      bit acc_deq;
      acc_enq = enq_valid && (mq.size() < DEPTH);
      acc_deq = deq_ready && (mq.size() > 0);
      if (acc_deq) void'(mq.pop_front());
      if (acc_enq) mq.push_back({enq_chosen, enq_bits});
    end
  end

  // Per-cycle comparison against the model, mid-cycle away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      check("m_enq_ready", 32'(enq_ready), 32'(mq.size() < DEPTH));
      check("m_deq_valid", 32'(deq_valid), 32'(mq.size() > 0));
      check("m_count", 32'(count), 32'(mq.size()));
      if (mq.size() > 0) begin
        check("m_head", 32'({deq_chosen, deq_bits}), 32'(mq[0]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] b, input logic [1:0] t, input logic r);
    enq_valid  = v;
    enq_bits   = b;
    enq_chosen = t;
    deq_ready  = r;
  endtask

  initial begin
    logic [7:0] fill_b[4];
    fill_b = '{8'h11, 8'h22, 8'h33, 8'h44};
    reset = 1'b0;
    drive(1'b0, 8'h00, 2'd0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;

    // Reset then idle
    check("rst_enq_ready", 32'(enq_ready), 32'd1);
    check("rst_deq_valid", 32'(deq_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_bits", 32'(deq_bits), 32'h00);
    check("rst_chosen", 32'(deq_chosen), 32'd0);
    step();

    // Fill to full
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, fill_b[i], 2'(i), 1'b0);
      step();
      check("fill_count", 32'(count), 32'(i + 1));
    end
    check("full_enq_ready", 32'(enq_ready), 32'd0);
    check("full_deq_valid", 32'(deq_valid), 32'd1);
    check("full_head", 32'({deq_chosen, deq_bits}), 32'({2'd0, 8'h11}));
    drive(1'b1, 8'h55, 2'd1, 1'b0);
    step();
    check("reject_count", 32'(count), 32'd4);

    // Drain in order
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 8'h00, 2'd0, 1'b1);
      check("drain_head", 32'({deq_chosen, deq_bits}), 32'({2'(i), fill_b[i]}));
      step();
      check("drain_count", 32'(count), 32'(3 - i));
    end
    check("drain_deq_valid", 32'(deq_valid), 32'd0);

    // Prime to count 2, then stream with simultaneous enq/deq across the wrap
    drive(1'b1, 8'hB0, 2'd1, 1'b0);
    step();
    drive(1'b1, 8'hB1, 2'd2, 1'b0);
    step();
    check("prime_count", 32'(count), 32'd2);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 8'(8'hA0 + i), 2'(i), 1'b1);
      step();
      check("stream_count", 32'(count), 32'd2);
    end
    check("stream_head", 32'({deq_chosen, deq_bits}), 32'({2'd0, 8'hA8}));

    // Fill to 4, then simultaneous request while full
    drive(1'b1, 8'hC0, 2'd3, 1'b0);
    step();
    drive(1'b1, 8'hC1, 2'd0, 1'b0);
    step();
    check("refill_count", 32'(count), 32'd4);
    drive(1'b1, 8'h77, 2'd3, 1'b1);
    step();
    check("fullsim_count", 32'(count), 32'd3);
    check("fullsim_head", 32'({deq_chosen, deq_bits}), 32'({2'd1, 8'hA9}));
    drive(1'b1, 8'h77, 2'd3, 1'b0);
    step();
    check("accept77_count", 32'(count), 32'd4);
    drive(1'b0, 8'h00, 2'd0, 1'b1);
    step();
    check("pre_rst_count", 32'(count), 32'd3);
    drive(1'b0, 8'h00, 2'd0, 1'b0);

    // Asynchronous reset between edges
    #1 reset = 1'b0;
    #1;
    check("arst_count", 32'(count), 32'd0);
    check("arst_deq_valid", 32'(deq_valid), 32'd0);
    check("arst_enq_ready", 32'(enq_ready), 32'd1);
    check("arst_bits", 32'(deq_bits), 32'h00);
    #1 reset = 1'b1;
    drive(1'b1, 8'h5A, 2'd2, 1'b0);
    check("post_rst_empty", 32'(deq_valid), 32'd0);
    step();
    drive(1'b0, 8'h00, 2'd0, 1'b0);
    check("post_rst_valid", 32'(deq_valid), 32'd1);
    check("post_rst_head", 32'({deq_chosen, deq_bits}), 32'({2'd2, 8'h5A}));
    check("post_rst_count", 32'(count), 32'd1);
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arb_out_queue.md
# arb_out_queue

Registered FIFO that sits directly downstream of the 4-input round-robin arbiter. It captures each granted beat (8-bit payload plus the 2-bit grant index) on the arbiter's output handshake. It then presents the beats in order to the consumer, decoupling the consumer's backpressure from the arbiter's grant pointer. The reported occupancy count feeds credit and statistics logic.

## Interface
- DEPTH, 4, number of entries; power of two, >= 2
- WIDTH, 8, payload width
- TAG_W, 2, grant-index (source tag) width
- clk  in  1  clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0); clears all state immediately, released synchronously to clk by the system
- io_enq_valid  in  1  arbiter output beat valid
- io_enq_ready  out  1  queue can accept a beat
- io_enq_bits  in  WIDTH  arbiter output payload
- io_enq_chosen  in  TAG_W  arbiter grant index for this beat
- io_deq_valid  out  1  head entry valid
- io_deq_ready  in  1  consumer accepts head
- io_deq_bits  out  WIDTH  head payload
- io_deq_chosen  out  TAG_W  head grant index
- io_count  out  log2(DEPTH)+1  current occupancy, 0..DEPTH

## Operation
- State:
  - storage array of DEPTH entries, each {chosen, bits}
  - enq pointer and deq pointer, each log2(DEPTH) bits
  - maybe_full flag
- Full and empty:
  - empty = (enq_ptr == deq_ptr) & !maybe_full
  - full = (enq_ptr == deq_ptr) & maybe_full
- Handshake outputs:
  - io_enq_ready = !full; it does not depend on io_deq_ready, so there is no comb path from deq to enq.
  - io_deq_valid = !empty. There is no flow-through: an empty queue never presents the enq beat on the same cycle.
- do_enq = io_enq_valid & io_enq_ready: write {io_enq_chosen, io_enq_bits} to storage[enq_ptr], then increment enq_ptr modulo DEPTH (natural wrap).
- do_deq = io_deq_valid & io_deq_ready: increment deq_ptr modulo DEPTH. Storage is not cleared.
- maybe_full update:
  - if do_enq != do_deq, maybe_full <= do_enq
  - otherwise it holds
- Simultaneous enq and deq:
  - Non-empty and not full: both pointers advance, count unchanged.
  - Full: enq_ready = 0, so only the deq occurs.
  - Empty: deq_valid = 0, so only the enq occurs.
- io_deq_bits and io_deq_chosen = storage[deq_ptr]. When empty these outputs are don't-care for the consumer, but they are deterministic (last stored or reset value).
- io_count:
  - equals (enq_ptr - deq_ptr) mod DEPTH
  - except when full, where it equals DEPTH
  - zero-extended to the count width
- Payload and tag are carried unmodified; there is no arithmetic on data.
- Invalid tag values do not exist for TAG_W = 2; all 4 tags are stored as-is.

## Timing
- Reset (reset = 0, asynchronous) forces:
  - enq_ptr = 0, deq_ptr = 0, maybe_full = 0
  - all storage = 0
- Resulting output values while in or just out of reset:
  - io_enq_ready = 1
  - io_deq_valid = 0
  - io_deq_bits = 0
  - io_deq_chosen = 0
  - io_count = 0
- Reset mid-operation: all buffered beats are discarded immediately, and outputs take their reset values without waiting for a clock edge.
- Latency: a beat enqueued at edge N is visible on io_deq_* after edge N (one-cycle minimum latency).
- Throughput: one enq and one deq per cycle, sustained, when 0 < count < DEPTH.
- All outputs are functions of registered state only; there are no combinational input-to-output paths.

## Test plan
- Reset then idle: hold reset = 0 for 2 cycles, release with valid inputs low.
  - Required: enq_ready = 1, deq_valid = 0, count = 0, deq_bits = 0x00, deq_chosen = 0.
- Fill to full: enq beats 0x11/tag 0, 0x22/tag 1, 0x33/tag 2, 0x44/tag 3 with deq_ready = 0.
  - Required: count steps 1, 2, 3, 4.
  - After the 4th edge: enq_ready = 0, deq_valid = 1, head = 0x11/tag 0.
  - A 5th offered beat 0x55 is not accepted.
- Drain in order: from full, set deq_ready = 1 for 4 cycles.
  - Required: outputs in order 0x11/0, 0x22/1, 0x33/2, 0x44/3.
  - count steps 3, 2, 1, 0; deq_valid = 0 after the 4th edge.
- Simultaneous enq/deq and wrap-around: with count = 2, stream 10 beats 0xA0..0xA9 with deq_ready = 1 every cycle.
  - Required: count stays 2 and order is preserved.
  - Pointers wrap past DEPTH-1 with no lost or duplicated beat.
- Full with simultaneous request: at count = 4, offer enq 0x77 with deq_ready = 1.
  - Required: only the deq occurs and count = 3.
  - 0x77 is accepted on the following cycle.
- Asynchronous reset mid-stream: at count = 3, drop reset between clock edges.
  - Required: count = 0, deq_valid = 0, enq_ready = 1 immediately.
  - After release, the first enq of 0x5A/tag 2 appears at the head one cycle later.
